// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Captures the 4-bit adder result {cout,sum} (0..30) into a 5-bit register,
// converts it to decimal and time-multiplexes three common-anode 7-segment
// digits: ones, tens (leading-zero blanked) and a carry indicator ('C').
// Each digit owns a slot of REFRESH_DIV clocks; the first BLANK_CYCLES clocks
// of every slot keep all anodes off so the previous digit's segments do not
// ghost onto the next anode. seg/an are registered and lag the scan position
// they decode by one clock.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   sum      in   [3:0] adder sum bits
//   cout     in   adder carry out
//   load     in   capture {cout,sum} on this edge
//   disp_en  in   1 = display on, 0 = all digits dark
//   seg      out  [6:0] {g,f,e,d,c,b,a}, active-low
//   an       out  [2:0] anodes, active-low; [0]=ones [1]=tens [2]=carry
// -----------------------------------------------------------------------------
module seg_scan_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sum,
    input  logic       cout,
    input  logic       load,
    input  logic       disp_en,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_C   = 7'b1000110;

    typedef enum logic [1:0] {
        SLOT_ONES  = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_CARRY = 2'd2
    } slot_t;

    slot_t            idx;
    slot_t            idx_next;
    logic [CNT_W-1:0] cnt;
    logic             slot_end;
    logic [4:0]       value_reg;
    logic [1:0]       tens;
    logic [3:0]       ones;
    logic             active;
    logic [6:0]       seg_next;
    logic [2:0]       an_next;

    // Threshold compare instead of a divider: the input range is only 0..31.
    function automatic logic [1:0] tens_of(input logic [4:0] v);
        if (v >= 5'd30)      return 2'd3;
        else if (v >= 5'd20) return 2'd2;
        else if (v >= 5'd10) return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [4:0] v, input logic [1:0] t);
        return 4'(v - 5'(t) * 5'd10);
    endfunction

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_OFF;
        endcase
    endfunction

    // Captured adder result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_reg <= 5'd0;
        end else if (load) begin
            value_reg <= {cout, sum};
        end
    end

    assign tens = tens_of(value_reg);
    assign ones = ones_of(value_reg, tens);

    // Slot counter and digit-slot state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= SLOT_ONES;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            idx <= idx_next;
        end
    end

    always_comb begin
        idx_next = idx;
        slot_end = (cnt == CNT_LAST);
        if (slot_end) begin
            case (idx)
                SLOT_ONES: idx_next = SLOT_TENS;
                SLOT_TENS: idx_next = SLOT_CARRY;
                default:   idx_next = SLOT_ONES;
            endcase
        end
    end

    // Output decode; blanking window covers the start of every slot
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = 3'b111;
        active   = disp_en && (cnt >= CNT_BLANK);
        if (active) begin
            case (idx)
                SLOT_ONES: begin
                    an_next  = 3'b110;
                    seg_next = digit_pattern(ones);
                end
                SLOT_TENS: begin
                    an_next  = 3'b101;
                    seg_next = (tens == 2'd0) ? SEG_OFF : digit_pattern({2'b00, tens});
                end
                SLOT_CARRY: begin
                    an_next  = 3'b011;
                    seg_next = value_reg[4] ? SEG_C : SEG_OFF;
                end
                default: begin
                    an_next  = 3'b111;
                    seg_next = SEG_OFF;
                end
            endcase
        end
    end

    // Registered outputs, one clock behind (cnt, idx)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= 3'b111;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    localparam int RD = 8;
    localparam int BL = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] sum;
    logic       cout;
    logic       load;
    logic       disp_en;
    logic [6:0] seg;
    logic [2:0] an;

    int tests = 0;
    int fails = 0;

    // Reference model state: p = clocks since reset release (the scan
    // position the next edge decodes), mval = value the display should show.
    int         p = 0;
    logic [4:0] mval = 5'd0;
    logic [6:0] exp_seg;
    logic [2:0] exp_an;

    logic [6:0] digit_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

    seg_scan_display #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sum    (sum),
        .cout   (cout),
        .load   (load),
        .disp_en(disp_en),
        .seg    (seg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] digit(input int d);
        if (d < 0 || d > 9) return 7'b1111111;
        return digit_tab[d];
    endfunction

    // One clock: predict outputs from the inputs presented to this edge,
    // advance the model, then compare just after the edge.
    task automatic step();
        int c;
        int s;
        int v;
        v = int'(mval);
        c = p % RD;
        s = (p / RD) % 3;
        exp_an  = 3'b111;
        exp_seg = 7'b1111111;
        if (rst_n && disp_en && c >= BL) begin
            case (s)
                0: begin
                    exp_an  = 3'b110;
                    exp_seg = digit(v % 10);
                end
                1: begin
                    exp_an  = 3'b101;
                    exp_seg = (v / 10 == 0) ? 7'b1111111 : digit(v / 10);
                end
                default: begin
                    exp_an  = 3'b011;
                    exp_seg = (v >= 16) ? 7'b1000110 : 7'b1111111;
                end
            endcase
        end
        @(posedge clk);
        if (!rst_n) begin
            p    = 0;
            mval = 5'd0;
        end else begin
            p = p + 1;
            if (load) mval = {cout, sum};
        end
        #1;
        tests++;
        assert (an === exp_an) else begin
            fails++;
            $error("FAIL an p=%0d observed=%b expected=%b", p, an, exp_an);
        end
        tests++;
        assert (seg === exp_seg) else begin
            fails++;
            $error("FAIL seg p=%0d observed=%b expected=%b", p, seg, exp_seg);
        end
        tests++;
        assert ($countones(~an) <= 1) else begin
            fails++;
            $error("FAIL onehot_an p=%0d observed=%b expected=at_most_one_low", p, an);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_val(input int v);
        logic [4:0] lv;
        lv   = 5'(v);
        sum  = lv[3:0];
        cout = lv[4];
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic advance_to(input int c);
        for (int i = 0; i < RD && (p % RD) != c; i++) step();
    endtask

    initial begin
        rst_n   = 1'b0;
        sum     = 4'd0;
        cout    = 1'b0;
        load    = 1'b0;
        disp_en = 1'b1;

        // Reset state, then two full scan periods showing value 0
        run(3);
        rst_n = 1'b1;
        run(2 * 3 * RD);

        // Directed values through full scan periods
        load_val(12);
        run(3 * RD);
        load_val(18);
        run(3 * RD);
        load_val(30);
        run(3 * RD);
        load_val(5);
        run(3 * RD);
        load_val(31);
        run(3 * RD);

        // Drop display mid-slot, then resume
        advance_to(4);
        disp_en = 1'b0;
        run(2);
        disp_en = 1'b1;
        run(RD + 2);

        // Load exactly on the slot-wrap edge
        advance_to(RD - 1);
        load_val(27);
        run(RD);
        advance_to(RD - 1);
        load_val(9);
        run(2 * RD);

        // Reset mid-slot with a pending load
        load_val(23);
        advance_to(5);
        sum   = 4'hF;
        cout  = 1'b1;
        load  = 1'b1;
        rst_n = 1'b0;
        step();
        load  = 1'b0;
        rst_n = 1'b1;
        run(3 * RD + 4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            load    = ($urandom_range(3) == 0);
            sum     = 4'($urandom);
            cout    = 1'($urandom);
            disp_en = ($urandom_range(9) != 0);
            rst_n   = ($urandom_range(59) != 0);
            step();
        end
        rst_n   = 1'b1;
        load    = 1'b0;
        disp_en = 1'b1;
        run(3 * RD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
